// File: rtl/exc_ctrl.sv
// Exception controller: tracks faults through the E and M stages, arbitrates
// interrupt / exception / ERET commits at M, and flushes the pipe for one cycle
// after each redirect.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        d_valid,
  input  logic        d_in_ds,
  input  logic [31:0] d_pc,
  input  logic        f_adel,
  input  logic        d_ri,
  input  logic        d_sys,
  input  logic        d_bp,
  input  logic        d_eret,
  input  logic        e_ov,
  input  logic        e_adel,
  input  logic        e_ades,
  input  logic [31:0] e_badaddr,
  input  logic        e_cp0_write,
  input  logic        interrupt,
  input  logic [31:0] cp0_epc,
  output logic        exception,
  output logic        ERET2pc,
  output logic        inDelaySlot,
  output logic        isBadAddr,
  output logic        cp0_write,
  output logic [5:0]  m_excCode,
  output logic [31:0] excPC,
  output logic [31:0] invalid_addr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 6;

  localparam logic [CW-1:0] CODE_INT  = CW'(0);
  localparam logic [CW-1:0] CODE_ADEL = CW'(4);
  localparam logic [CW-1:0] CODE_ADES = CW'(5);
  localparam logic [CW-1:0] CODE_SYS  = CW'(8);
  localparam logic [CW-1:0] CODE_BP   = CW'(9);
  localparam logic [CW-1:0] CODE_RI   = CW'(10);
  localparam logic [CW-1:0] CODE_OV   = CW'(12);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] pc;
    logic          in_ds;
    logic          exc;
    logic [CW-1:0] code;
    logic          bad;
    logic [AW-1:0] badaddr;
    logic          eret;
    logic          wr;
  } rec_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state, state_nxt;
  rec_t   e_rec, m_rec, e_nxt, m_nxt;

  logic commit_eval;
  logic take_int;
  logic take_exc;
  logic take_eret;
  logic take;

  // Commit arbitration at M: interrupt beats recorded fault beats ERET.
  always_comb begin
    commit_eval = (state == RUN) && !stall && m_rec.valid;
    take_int    = commit_eval && interrupt;
    take_exc    = commit_eval && (interrupt || m_rec.exc);
    take_eret   = commit_eval && !take_exc && m_rec.eret;
    take        = take_exc || take_eret;
  end

  // Decode-stage fault capture into the next E record, first match wins.
  always_comb begin
    e_nxt       = '0;
    e_nxt.valid = d_valid;
    e_nxt.pc    = d_pc;
    e_nxt.in_ds = d_in_ds;
    e_nxt.eret  = d_eret;
    if (f_adel) begin
      e_nxt.exc     = 1'b1;
      e_nxt.code    = CODE_ADEL;
      e_nxt.bad     = 1'b1;
      e_nxt.badaddr = d_pc;
    end else if (d_ri) begin
      e_nxt.exc  = 1'b1;
      e_nxt.code = CODE_RI;
    end else if (d_sys) begin
      e_nxt.exc  = 1'b1;
      e_nxt.code = CODE_SYS;
    end else if (d_bp) begin
      e_nxt.exc  = 1'b1;
      e_nxt.code = CODE_BP;
    end
    if (e_nxt.exc) begin
      e_nxt.eret = 1'b0;
      e_nxt.wr   = 1'b0;
    end
  end

  // Execute-stage faults only apply when the instruction is still clean.
  always_comb begin
    m_nxt    = e_rec;
    m_nxt.wr = e_cp0_write;
    if (!e_rec.exc) begin
      if (e_ov) begin
        m_nxt.exc  = 1'b1;
        m_nxt.code = CODE_OV;
      end else if (e_adel) begin
        m_nxt.exc     = 1'b1;
        m_nxt.code    = CODE_ADEL;
        m_nxt.bad     = 1'b1;
        m_nxt.badaddr = e_badaddr;
      end else if (e_ades) begin
        m_nxt.exc     = 1'b1;
        m_nxt.code    = CODE_ADES;
        m_nxt.bad     = 1'b1;
        m_nxt.badaddr = e_badaddr;
      end
    end
    if (m_nxt.exc) begin
      m_nxt.eret = 1'b0;
      m_nxt.wr   = 1'b0;
    end
  end

  // Pipeline records: cleared on reset and on a redirect, held on stall.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      e_rec <= '0;
      m_rec <= '0;
    end else if (take) begin
      e_rec <= '0;
      m_rec <= '0;
    end else if (!stall) begin
      e_rec <= e_nxt;
      m_rec <= m_nxt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a redirect costs exactly one FLUSH cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (take) state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Commit outputs; the redirect target idles at the exception vector.
  always_comb begin
    exception      = 1'b0;
    ERET2pc        = 1'b0;
    inDelaySlot    = 1'b0;
    isBadAddr      = 1'b0;
    m_excCode      = '0;
    excPC          = '0;
    invalid_addr   = '0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = EXC_VECTOR;
    cp0_write      = m_rec.wr && m_rec.valid && !stall && !take_exc;
    if (take_exc) begin
      exception      = 1'b1;
      flush          = 1'b1;
      redirect_valid = 1'b1;
      excPC          = m_rec.pc;
      inDelaySlot    = m_rec.in_ds;
      if (take_int) begin
        m_excCode = CODE_INT;
      end else begin
        m_excCode    = m_rec.code;
        isBadAddr    = m_rec.bad;
        invalid_addr = m_rec.badaddr;
      end
    end else if (take_eret) begin
      ERET2pc        = 1'b1;
      flush          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = cp0_epc;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: an instruction-level pipeline model predicts
// commits and mtc0 writes; a negedge monitor matches them against the DUT.
module tb_exc_ctrl;

  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0;
  logic        d_valid = 1'b0, d_in_ds = 1'b0;
  logic [31:0] d_pc = '0;
  logic        f_adel = 1'b0, d_ri = 1'b0, d_sys = 1'b0, d_bp = 1'b0, d_eret = 1'b0;
  logic        e_ov = 1'b0, e_adel = 1'b0, e_ades = 1'b0;
  logic [31:0] e_badaddr = '0;
  logic        e_cp0_write = 1'b0, interrupt = 1'b0;
  logic [31:0] cp0_epc = '0;
  logic        exception, ERET2pc, inDelaySlot, isBadAddr, cp0_write;
  logic [5:0]  m_excCode;
  logic [31:0] excPC, invalid_addr;
  logic        flush, redirect_valid;
  logic [31:0] redirect_pc;

  exc_ctrl #(.EXC_VECTOR(EXC_VEC)) dut (
    .clk(clk), .resetn(resetn), .stall(stall),
    .d_valid(d_valid), .d_in_ds(d_in_ds), .d_pc(d_pc),
    .f_adel(f_adel), .d_ri(d_ri), .d_sys(d_sys), .d_bp(d_bp), .d_eret(d_eret),
    .e_ov(e_ov), .e_adel(e_adel), .e_ades(e_ades), .e_badaddr(e_badaddr),
    .e_cp0_write(e_cp0_write), .interrupt(interrupt), .cp0_epc(cp0_epc),
    .exception(exception), .ERET2pc(ERET2pc), .inDelaySlot(inDelaySlot),
    .isBadAddr(isBadAddr), .cp0_write(cp0_write), .m_excCode(m_excCode),
    .excPC(excPC), .invalid_addr(invalid_addr), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // One instruction with every fault it will raise over its life.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        in_ds;
    logic        f_adel, ri, sys, bp, eret, ov, e_adel, e_ades, wr;
    logic [31:0] badaddr;
  } instr_t;

  typedef struct {
    int unsigned cyc;
    logic        is_exc;
    logic [5:0]  code;
    logic        bad;
    logic [31:0] baddr;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] rpc;
  } evt_t;

  evt_t        evq[$];
  int unsigned wrq[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  instr_t e_slot = '0;
  instr_t m_slot = '0;
  bit     in_flush = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Program-order fault priority: fetch, decode, then execute faults.
  function automatic void classify(input instr_t i, output logic has, output logic [5:0] code,
                                   output logic bad, output logic [31:0] ba);
    has = 1'b1; bad = 1'b0; ba = '0; code = 6'd0;
    if (i.f_adel)      begin code = 6'd4; bad = 1'b1; ba = i.pc; end
    else if (i.ri)     code = 6'd10;
    else if (i.sys)    code = 6'd8;
    else if (i.bp)     code = 6'd9;
    else if (i.ov)     code = 6'd12;
    else if (i.e_adel) begin code = 6'd4; bad = 1'b1; ba = i.badaddr; end
    else if (i.e_ades) begin code = 6'd5; bad = 1'b1; ba = i.badaddr; end
    else               has = 1'b0;
  endfunction

  // Drive one cycle of stimulus, predict its commit, then advance the model.
  task automatic step(input instr_t d, input bit st, input bit irq, input bit rn,
                      input logic [31:0] epc);
    logic has, bad, ev, tx, te;
    logic [5:0] code;
    logic [31:0] ba;
    evt_t e;
    @(posedge clk); #1;
    resetn = rn; stall = st; interrupt = irq; cp0_epc = epc;
    d_valid = d.valid; d_pc = d.pc; d_in_ds = d.in_ds;
    f_adel = d.f_adel; d_ri = d.ri; d_sys = d.sys; d_bp = d.bp; d_eret = d.eret;
    e_ov = e_slot.ov; e_adel = e_slot.e_adel; e_ades = e_slot.e_ades;
    e_badaddr = e_slot.badaddr; e_cp0_write = e_slot.wr;
    cyc++;
    classify(m_slot, has, code, bad, ba);
    ev = !in_flush && !st && m_slot.valid;
    tx = ev && (irq || has);
    te = ev && !tx && m_slot.eret;
    if (tx || te) begin
      e.cyc = cyc; e.is_exc = tx;
      e.code = irq ? 6'd0 : code;
      e.bad = irq ? 1'b0 : bad;
      e.baddr = irq ? 32'd0 : ba;
      e.pc = m_slot.pc; e.ds = m_slot.in_ds;
      e.rpc = tx ? EXC_VEC : epc;
      evq.push_back(e);
    end
    if (m_slot.valid && m_slot.wr && !has && !st && !tx) wrq.push_back(cyc);
    if (!rn) begin
      e_slot = '0; m_slot = '0; in_flush = 1'b0;
    end else if (tx || te) begin
      e_slot = '0; m_slot = '0; in_flush = 1'b1;
    end else begin
      in_flush = 1'b0;
      if (!st) begin
        m_slot = e_slot;
        e_slot = d;
      end
    end
  endtask

  task automatic check_reset_outs();
    @(negedge clk);
    chk("rst_exception", 32'(exception), 0);
    chk("rst_eret2pc", 32'(ERET2pc), 0);
    chk("rst_in_ds", 32'(inDelaySlot), 0);
    chk("rst_bad", 32'(isBadAddr), 0);
    chk("rst_cp0_write", 32'(cp0_write), 0);
    chk("rst_code", 32'(m_excCode), 0);
    chk("rst_excpc", excPC, 0);
    chk("rst_invalid_addr", invalid_addr, 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_redirect_valid", 32'(redirect_valid), 0);
    chk("rst_redirect_pc", redirect_pc, EXC_VEC);
  endtask

  function automatic instr_t rnd_instr();
    instr_t i;
    i.valid   = ($urandom_range(0, 9) < 8);
    i.pc      = $urandom;
    i.in_ds   = ($urandom_range(0, 1) == 1);
    i.f_adel  = ($urandom_range(0, 24) == 0);
    i.ri      = ($urandom_range(0, 24) == 0);
    i.sys     = ($urandom_range(0, 24) == 0);
    i.bp      = ($urandom_range(0, 24) == 0);
    i.eret    = ($urandom_range(0, 12) == 0);
    i.ov      = ($urandom_range(0, 24) == 0);
    i.e_adel  = ($urandom_range(0, 24) == 0);
    i.e_ades  = ($urandom_range(0, 24) == 0);
    i.wr      = ($urandom_range(0, 4) == 0);
    i.badaddr = $urandom;
    return i;
  endfunction

  // Monitor: match DUT commits and mtc0 writes against predicted events.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      evt_t e;
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        chk("missed_commit", 0, 1);
        void'(evq.pop_front());
      end
      if (flush) begin
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
          e = evq.pop_front();
          chk("exception", 32'(exception), 32'(e.is_exc));
          chk("eret2pc", 32'(ERET2pc), 32'(!e.is_exc));
          chk("redirect_valid", 32'(redirect_valid), 1);
          chk("redirect_pc", redirect_pc, e.rpc);
          if (e.is_exc) begin
            chk("exc_code", 32'(m_excCode), 32'(e.code));
            chk("bad_addr_flag", 32'(isBadAddr), 32'(e.bad));
            chk("exc_pc", excPC, e.pc);
            chk("in_delay_slot", 32'(inDelaySlot), 32'(e.ds));
            if (e.bad) chk("invalid_addr", invalid_addr, e.baddr);
          end
        end else begin
          chk("spurious_commit", 32'(flush), 0);
        end
      end else begin
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
          void'(evq.pop_front());
          chk("missing_commit", 32'(flush), 1);
        end
        chk("idle_commit_outs", 32'({exception, ERET2pc, redirect_valid}), 0);
      end
      chk("exc_eret_exclusive", 32'(exception & ERET2pc), 0);
      while (wrq.size() > 0 && wrq[0] < cyc) begin
        chk("missed_cp0_write", 0, 1);
        void'(wrq.pop_front());
      end
      if (wrq.size() > 0 && wrq[0] == cyc) begin
        void'(wrq.pop_front());
        chk("cp0_write", 32'(cp0_write), 1);
      end else begin
        chk("cp0_write_idle", 32'(cp0_write), 0);
      end
    end
  end

  initial begin
    instr_t bub, i, a;
    bub = '0;
    for (int k = 0; k < 3; k++) step(bub, 1'b0, 1'b0, 1'b0, 32'd0);
    step(bub, 1'b0, 1'b0, 1'b1, 32'd0);
    check_reset_outs();

    // syscall: commits two cycles after decode, then one flush cycle
    i = '0; i.valid = 1'b1; i.sys = 1'b1; i.pc = 32'h8000_0010;
    step(i, 1'b0, 1'b0, 1'b1, 32'd0);
    for (int k = 0; k < 3; k++) step(bub, 1'b0, 1'b0, 1'b1, 32'd0);

    // store address error in a delay slot
    i = '0; i.valid = 1'b1; i.in_ds = 1'b1; i.pc = 32'h8000_0020;
    i.e_ades = 1'b1; i.badaddr = 32'h0000_1003;
    step(i, 1'b0, 1'b0, 1'b1, 32'd0);
    for (int k = 0; k < 3; k++) step(bub, 1'b0, 1'b0, 1'b1, 32'd0);

    // fetch fault beats reserved-instruction and overflow on the same instr
    i = '0; i.valid = 1'b1; i.pc = 32'h8000_0101; i.f_adel = 1'b1; i.ri = 1'b1; i.ov = 1'b1;
    step(i, 1'b0, 1'b0, 1'b1, 32'd0);
    for (int k = 0; k < 3; k++) step(bub, 1'b0, 1'b0, 1'b1, 32'd0);

    // eret redirects to the EPC
    i = '0; i.valid = 1'b1; i.pc = 32'h8000_0040; i.eret = 1'b1;
    step(i, 1'b0, 1'b0, 1'b1, 32'h8000_0200);
    for (int k = 0; k < 3; k++) step(bub, 1'b0, 1'b0, 1'b1, 32'h8000_0200);

    // interrupt on an mtc0 held in M by a three-cycle stall
    i = '0; i.valid = 1'b1; i.pc = 32'h8000_0050; i.wr = 1'b1;
    step(i, 1'b0, 1'b0, 1'b1, 32'd0);
    step(bub, 1'b0, 1'b0, 1'b1, 32'd0);
    for (int k = 0; k < 3; k++) step(bub, 1'b1, 1'b1, 1'b1, 32'd0);
    step(bub, 1'b0, 1'b1, 1'b1, 32'd0);
    step(bub, 1'b0, 1'b0, 1'b1, 32'd0);

    // reset asserted during the flush cycle with valid work behind it
    a = '0; a.valid = 1'b1; a.sys = 1'b1; a.pc = 32'h8000_0060;
    i = '0; i.valid = 1'b1; i.pc = 32'h8000_0064;
    step(a, 1'b0, 1'b0, 1'b1, 32'd0);
    step(i, 1'b0, 1'b0, 1'b1, 32'd0);
    step(i, 1'b0, 1'b0, 1'b1, 32'd0);
    step(i, 1'b0, 1'b0, 1'b0, 32'd0);
    step(bub, 1'b0, 1'b0, 1'b1, 32'd0);
    check_reset_outs();
    step(bub, 1'b0, 1'b1, 1'b1, 32'd0);
    step(bub, 1'b0, 1'b1, 1'b1, 32'd0);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      step(rnd_instr(), ($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 149) != 0), $urandom);
    end

    for (int k = 0; k < 4; k++) step(bub, 1'b0, 1'b0, 1'b1, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("commit_queue_drained", 32'(evq.size()), 0);
    chk("cp0_queue_drained", 32'(wrq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'hBFC0_0380, the exception handler entry PC.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port stall  in  1  pipeline hold: records hold and no commit occurs.
REQ-005 SHALL have ports d_valid/d_in_ds  in  1/1  decode instruction valid / instruction is in a delay slot; d_pc  in  32  decode PC.
REQ-006 SHALL have ports f_adel, d_ri, d_sys, d_bp, d_eret  in  1 each  fetch misaligned / reserved instr / syscall / break / eret.
REQ-007 SHALL have ports e_ov, e_adel, e_ades  in  1 each, and e_badaddr  in  32  execute-stage faults and data address.
REQ-008 SHALL have ports e_cp0_write  in  1  mtc0 request; interrupt  in  1  from CP0; cp0_epc  in  32  from CP0.
REQ-009 SHALL have outputs exception, ERET2pc, inDelaySlot, isBadAddr, cp0_write  1 each; m_excCode  6; excPC, invalid_addr  32 each.
REQ-010 SHALL have outputs flush  1; redirect_valid  1; redirect_pc  32.

Function
REQ-011 SHALL hold two records, E-rec and M-rec: {valid, pc, in_ds, exc, code[5:0], bad, badaddr[31:0], eret, wr}.
REQ-012 When stall=0, E-rec SHALL load at each edge from the d_* inputs: valid=d_valid, pc=d_pc, in_ds=d_in_ds, eret=d_eret.
REQ-013 E-rec load priority: f_adel -> code 4 with bad=1 and badaddr=d_pc; then d_ri -> 10; then d_sys -> 8; then d_bp -> 9. The first match sets exc=1; later matches are ignored.
REQ-014 When stall=0, M-rec SHALL load from E-rec; if E-rec.exc=0, add e_ov -> 12, then e_adel -> 4, then e_ades -> 5. AdEL and AdES set bad=1 and badaddr=e_badaddr. wr=e_cp0_write.
REQ-015 A record with exc=1 SHALL clear its eret and wr; the earliest-stage fault always wins.
REQ-016 FSM SHALL have states RUN and FLUSH; a commit is evaluated only in RUN with stall=0 and M-rec.valid=1.
REQ-017 Interrupt commit: interrupt=1 at commit evaluation SHALL take priority over M-rec contents. Outputs: exception=1, m_excCode=0, isBadAddr=0.
REQ-018 Exception commit: M-rec.exc=1 SHALL drive exception=1, m_excCode=code, isBadAddr=bad and invalid_addr=badaddr.
REQ-019 For every exception commit, excPC=M-rec.pc and inDelaySlot=M-rec.in_ds; the CP0 side applies the -4 EPC adjust.
REQ-020 ERET commit: M-rec.eret=1 with no exception SHALL drive ERET2pc=1, redirect_pc=cp0_epc.
REQ-021 Exception commit SHALL drive redirect_pc=EXC_VECTOR.
REQ-022 On any commit, flush=1 and redirect_valid=1 SHALL be asserted combinationally in that cycle. At the next edge, E-rec.valid and M-rec.valid SHALL clear and the FSM SHALL go to FLUSH.
REQ-023 FLUSH SHALL last exactly one cycle and return to RUN. In FLUSH, all commit outputs are 0, interrupt is ignored, and records load normally.
REQ-024 cp0_write SHALL be M-rec.wr & M-rec.valid & ~stall & ~exception, so an mtc0 is suppressed when an interrupt is taken on it.
REQ-025 Bubble (M-rec.valid=0) SHALL never commit; a pending interrupt waits for the next valid M-rec.
REQ-026 All outputs SHALL be combinational from registered state plus interrupt, stall and cp0_epc. A fault seen in decode at cycle t appears on exception at t+2 when there is no stall, with +1 for each stall cycle.
REQ-027 exception and ERET2pc SHALL never be asserted in the same cycle.

Reset
REQ-028 With resetn=0 at an edge, the FSM SHALL go to RUN and all record fields SHALL clear, including mid-FLUSH or mid-stall.
REQ-029 After reset all outputs SHALL be 0 except redirect_pc, which SHALL be EXC_VECTOR.

Verification
REQ-030 Bench: d_valid=1, d_sys=1, d_pc=32'h8000_0010, no stall -> two cycles later exception=1, m_excCode=8, excPC=32'h8000_0010, redirect_pc=32'hBFC0_0380, flush=1; next cycle all commit outputs=0.
REQ-031 Bench: e_ades=1, e_badaddr=32'h0000_1003, in_ds=1 -> exception=1, m_excCode=5, isBadAddr=1, invalid_addr=32'h0000_1003, inDelaySlot=1.
REQ-032 Bench: f_adel=1 and d_ri=1 together, then e_ov=1 on the same instruction -> m_excCode=4 only.
REQ-033 Bench: d_eret=1 with cp0_epc=32'h8000_0200 -> ERET2pc=1, redirect_pc=32'h8000_0200, exception=0.
REQ-034 Bench: interrupt=1 while an mtc0 reaches M and stall=1 for 3 cycles -> no commit during the stall. At release: exception=1, code 0, cp0_write=0.
REQ-035 Bench: resetn=0 during FLUSH with E-rec and M-rec valid -> next cycle RUN, records invalid, all outputs at reset values.
